xres_seq_ctrl: RTL and testbench

- Digital sequencer for the XRES reset pad. Powers up and configures the pad controls (ENABLE_H, ENABLE_VDDIO, EN_VDDIO_SIG_H, INP_SEL_H, DISABLE_PULLUP_H) in a legal order.
- Synchronizes and glitch-filters XRES_H_N, then produces a stretched system reset SYS_RESET_N.
- Sits in the always-on domain beside the pad and drives the core reset tree.

---
 rtl/xres_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_xres_seq_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xres_seq_ctrl.sv
// XRES pad sequencer: powers up and configures the pad in a legal order, filters
// the pad reset output and produces a stretched system reset for the core.
module xres_seq_ctrl #(
    parameter int unsigned PWR_CYC    = 16,
    parameter int unsigned SETTLE_CYC = 32,
    parameter int unsigned FILT_CYC   = 4,
    parameter int unsigned HOLD_CYC   = 64,
    parameter int unsigned CNT_W      = 16
) (
    input  logic       CLK,
    input  logic       RESET_B,
    input  logic       PWR_GOOD_H,
    input  logic       VCCHIB_MODE,
    input  logic       USE_FILT,
    input  logic       SW_RESET,
    input  logic       XRES_H_N,
    output logic       ENABLE_H,
    output logic       ENABLE_VDDIO,
    output logic       EN_VDDIO_SIG_H,
    output logic       INP_SEL_H,
    output logic       DISABLE_PULLUP_H,
    output logic       SYS_RESET_N,
    output logic       GLITCH,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_CFG    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] PWR_LIM    = CNT_W'(PWR_CYC);
    localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] FILT_LIM   = CNT_W'(FILT_CYC);
    localparam logic [CNT_W-1:0] HOLD_LIM   = CNT_W'(HOLD_CYC);

    state_t           state_reg;
    logic [1:0]       meta_reg;
    logic [1:0]       sync_reg;
    logic             pg_s;
    logic             xr_s;
    logic             filt_reg;
    logic             filt_next;
    logic [CNT_W-1:0] fcnt_reg;
    logic [CNT_W-1:0] fcnt_next;
    logic [CNT_W-1:0] fcnt_inc;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_inc;
    logic             glitch_det;

    assign pg_s  = sync_reg[0];
    assign xr_s  = sync_reg[1];
    assign STATE = state_reg;

    // Saturating increments: both counters stick at all-ones instead of wrapping.
    assign cnt_inc  = (cnt_reg  == '1) ? cnt_reg  : cnt_reg  + 1'b1;
    assign fcnt_inc = (fcnt_reg == '1) ? fcnt_reg : fcnt_reg + 1'b1;

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= {XRES_H_N, PWR_GOOD_H};
            sync_reg <= meta_reg;
        end
    end

    // A level is accepted only after FILT_CYC consecutive differing samples;
    // a shorter excursion is reported as a rejected glitch.
    always_comb begin
        filt_next  = filt_reg;
        fcnt_next  = fcnt_reg;
        glitch_det = 1'b0;
        if (state_reg == ST_OFF) begin
            filt_next = 1'b0;
            fcnt_next = '0;
        end else if (xr_s != filt_reg) begin
            if (fcnt_inc == FILT_LIM) begin
                filt_next = xr_s;
                fcnt_next = '0;
            end else begin
                fcnt_next = fcnt_inc;
            end
        end else if (fcnt_reg != '0) begin
            fcnt_next  = '0;
            glitch_det = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state_reg        <= ST_OFF;
            cnt_reg          <= '0;
            fcnt_reg         <= '0;
            filt_reg         <= 1'b0;
            ENABLE_H         <= 1'b0;
            ENABLE_VDDIO     <= 1'b0;
            EN_VDDIO_SIG_H   <= 1'b1;
            INP_SEL_H        <= 1'b0;
            DISABLE_PULLUP_H <= 1'b1;
            SYS_RESET_N      <= 1'b0;
            GLITCH           <= 1'b0;
        end else begin
            filt_reg <= filt_next;
            fcnt_reg <= fcnt_next;
            GLITCH   <= glitch_det && (state_reg == ST_RUN || state_reg == ST_HOLD);
            // Power loss wins over everything and drops the pad back to safe defaults.
            if ((state_reg != ST_OFF && !pg_s) ||
                !(state_reg inside {ST_OFF, ST_CFG, ST_SETTLE, ST_RUN, ST_HOLD})) begin
                state_reg        <= ST_OFF;
                cnt_reg          <= '0;
                ENABLE_H         <= 1'b0;
                ENABLE_VDDIO     <= 1'b0;
                EN_VDDIO_SIG_H   <= 1'b1;
                INP_SEL_H        <= 1'b0;
                DISABLE_PULLUP_H <= 1'b1;
                SYS_RESET_N      <= 1'b0;
            end else begin
                case (state_reg)
                    ST_OFF: begin
                        if (!pg_s) begin
                            cnt_reg <= '0;
                        end else if (cnt_inc == PWR_LIM) begin
                            state_reg <= ST_CFG;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_inc;
                        end
                    end
                    ST_CFG: begin
                        ENABLE_H         <= 1'b1;
                        ENABLE_VDDIO     <= 1'b1;
                        EN_VDDIO_SIG_H   <= !VCCHIB_MODE;
                        INP_SEL_H        <= USE_FILT;
                        DISABLE_PULLUP_H <= 1'b0;
                        state_reg        <= ST_SETTLE;
                        cnt_reg          <= '0;
                    end
                    ST_SETTLE: begin
                        if (cnt_inc == SETTLE_LIM) begin
                            state_reg <= ST_HOLD;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_inc;
                        end
                    end
                    ST_HOLD: begin
                        SYS_RESET_N <= 1'b0;
                        if (filt_reg && !SW_RESET) begin
                            if (cnt_inc == HOLD_LIM) begin
                                state_reg   <= ST_RUN;
                                SYS_RESET_N <= 1'b1;
                                cnt_reg     <= '0;
                            end else begin
                                cnt_reg <= cnt_inc;
                            end
                        end else begin
                            cnt_reg <= '0;
                        end
                    end
                    default: begin
                        if (!filt_reg || SW_RESET) begin
                            state_reg   <= ST_HOLD;
                            SYS_RESET_N <= 1'b0;
                            cnt_reg     <= '0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_xres_seq_ctrl.sv
// Scoreboard bench for xres_seq_ctrl: each scenario queues the output vector it
// expects at given edges and checks it as the edges occur.
module tb_xres_seq_ctrl;

    logic       CLK = 1'b0;
    logic       RESET_B = 1'b0;
    logic       PWR_GOOD_H = 1'b1;
    logic       VCCHIB_MODE = 1'b0;
    logic       USE_FILT = 1'b0;
    logic       SW_RESET = 1'b0;
    logic       XRES_H_N = 1'b1;
    logic       ENABLE_H, ENABLE_VDDIO, EN_VDDIO_SIG_H, INP_SEL_H, DISABLE_PULLUP_H;
    logic       SYS_RESET_N, GLITCH;
    logic [2:0] STATE;

    xres_seq_ctrl #(
        .PWR_CYC(4), .SETTLE_CYC(8), .FILT_CYC(3), .HOLD_CYC(16), .CNT_W(16)
    ) dut (
        .CLK(CLK), .RESET_B(RESET_B), .PWR_GOOD_H(PWR_GOOD_H),
        .VCCHIB_MODE(VCCHIB_MODE), .USE_FILT(USE_FILT), .SW_RESET(SW_RESET),
        .XRES_H_N(XRES_H_N), .ENABLE_H(ENABLE_H), .ENABLE_VDDIO(ENABLE_VDDIO),
        .EN_VDDIO_SIG_H(EN_VDDIO_SIG_H), .INP_SEL_H(INP_SEL_H),
        .DISABLE_PULLUP_H(DISABLE_PULLUP_H), .SYS_RESET_N(SYS_RESET_N),
        .GLITCH(GLITCH), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         at_edge;
        logic [9:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t it;
    int   edge_cnt = 0;
    int   base = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    // Vector layout: EN, VDDIO, SIG, INP, DIS, SRN, GLITCH, STATE[2:0]
    function automatic logic [9:0] mk(input logic en, input logic sig, input logic inp,
                                      input logic dis, input logic srn, input logic gl,
                                      input logic [2:0] st);
        return {en, en, sig, inp, dis, srn, gl, st};
    endfunction

    function automatic logic [9:0] outs();
        return {ENABLE_H, ENABLE_VDDIO, EN_VDDIO_SIG_H, INP_SEL_H, DISABLE_PULLUP_H,
                SYS_RESET_N, GLITCH, STATE};
    endfunction

    localparam logic [9:0] V_OFF = 10'b00101_00_000;
    localparam logic [9:0] V_CFG = 10'b00101_00_001;

    task automatic expect_at(input int rel, input logic [9:0] val, input string name);
        sb.push_back('{base + rel, val, name});
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (outs() !== V_OFF) begin
            n_err++;
            $display("FAIL reset_outputs: got %b required %b", outs(), V_OFF);
        end
        PWR_GOOD_H = 1'b0;
        XRES_H_N   = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (outs() !== V_OFF) begin
            n_err++;
            $display("FAIL reset_inputs_ignored: got %b required %b", outs(), V_OFF);
        end
        PWR_GOOD_H = 1'b1;
        XRES_H_N   = 1'b1;
        $display("test_reset done");
    endtask

    // Entered with RESET_B low at a falling clock edge; leaves the DUT in RUN.
    task automatic test_power_up(input logic vcchib, input logic ufilt);
        logic [9:0] v;
        VCCHIB_MODE = vcchib;
        USE_FILT    = ufilt;
        SW_RESET    = 1'b0;
        XRES_H_N    = 1'b1;
        PWR_GOOD_H  = 1'b1;
        RESET_B     = 1'b1;
        base        = edge_cnt;
        for (int e = 1; e <= 31; e++) begin
            if (e < 6)       v = V_OFF;
            else if (e == 6) v = V_CFG;
            else if (e < 15) v = mk(1'b1, !vcchib, ufilt, 1'b0, 1'b0, 1'b0, 3'd2);
            else if (e < 31) v = mk(1'b1, !vcchib, ufilt, 1'b0, 1'b0, 1'b0, 3'd4);
            else             v = mk(1'b1, !vcchib, ufilt, 1'b0, 1'b1, 1'b0, 3'd3);
            expect_at(e, v, "power_up");
        end
        for (int c = 0; c < 31; c++) begin
            @(negedge CLK);
            while (sb.size() != 0 && sb[0].at_edge <= edge_cnt) begin
                it = sb.pop_front();
                n_cmp++;
                if (outs() !== it.val) begin
                    n_err++;
                    $display("FAIL %s edge+%0d: got %b required %b", it.name, it.at_edge - base, outs(), it.val);
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL power_up_pending: got %0d left required 0", sb.size());
            sb.delete();
        end
        $display("test_power_up vcchib=%0b use_filt=%0b done", vcchib, ufilt);
    endtask

    task automatic test_glitch();
        base = edge_cnt;
        for (int e = 1; e <= 8; e++)
            expect_at(e, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, (e == 5), 3'd3), "glitch");
        XRES_H_N = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            while (sb.size() != 0 && sb[0].at_edge <= edge_cnt) begin
                it = sb.pop_front();
                n_cmp++;
                if (outs() !== it.val) begin
                    n_err++;
                    $display("FAIL %s edge+%0d: got %b required %b", it.name, it.at_edge - base, outs(), it.val);
                end
            end
            if (c == 1) XRES_H_N = 1'b1;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL glitch_pending: got %0d left required 0", sb.size());
            sb.delete();
        end
        $display("test_glitch done");
    endtask

    task automatic test_real_reset();
        base = edge_cnt;
        for (int e = 1; e <= 31; e++) begin
            if (e < 6 || e == 31)
                expect_at(e, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3), "real_reset_run");
            else
                expect_at(e, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4), "real_reset_hold");
        end
        XRES_H_N = 1'b0;
        for (int c = 0; c < 31; c++) begin
            @(negedge CLK);
            while (sb.size() != 0 && sb[0].at_edge <= edge_cnt) begin
                it = sb.pop_front();
                n_cmp++;
                if (outs() !== it.val) begin
                    n_err++;
                    $display("FAIL %s edge+%0d: got %b required %b", it.name, it.at_edge - base, outs(), it.val);
                end
            end
            if (c == 9) XRES_H_N = 1'b1;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL real_reset_pending: got %0d left required 0", sb.size());
            sb.delete();
        end
        $display("test_real_reset done");
    endtask

    task automatic test_sw_reset();
        base = edge_cnt;
        for (int e = 1; e <= 17; e++)
            expect_at(e, mk(1'b1, 1'b1, 1'b0, 1'b0, (e == 17), 1'b0, (e == 17) ? 3'd3 : 3'd4), "sw_reset");
        SW_RESET = 1'b1;
        for (int c = 0; c < 17; c++) begin
            @(negedge CLK);
            while (sb.size() != 0 && sb[0].at_edge <= edge_cnt) begin
                it = sb.pop_front();
                n_cmp++;
                if (outs() !== it.val) begin
                    n_err++;
                    $display("FAIL %s edge+%0d: got %b required %b", it.name, it.at_edge - base, outs(), it.val);
                end
            end
            if (c == 0) SW_RESET = 1'b0;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sw_reset_pending: got %0d left required 0", sb.size());
            sb.delete();
        end
        $display("test_sw_reset done");
    endtask

    // Power loss from RUN, then a 2-cycle dropout in OFF that must restart the count.
    task automatic test_power_loss();
        base = edge_cnt;
        for (int e = 1; e <= 16; e++) begin
            if (e < 3)       expect_at(e, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3), "pwr_loss_run");
            else if (e < 15) expect_at(e, V_OFF, "pwr_loss_off");
            else if (e == 15) expect_at(e, V_CFG, "pwr_restart_cfg");
            else             expect_at(e, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2), "pwr_restart_settle");
        end
        PWR_GOOD_H = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge CLK);
            while (sb.size() != 0 && sb[0].at_edge <= edge_cnt) begin
                it = sb.pop_front();
                n_cmp++;
                if (outs() !== it.val) begin
                    n_err++;
                    $display("FAIL %s edge+%0d: got %b required %b", it.name, it.at_edge - base, outs(), it.val);
                end
            end
            if (c == 3) PWR_GOOD_H = 1'b1;
            if (c == 6) PWR_GOOD_H = 1'b0;
            if (c == 8) PWR_GOOD_H = 1'b1;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL power_loss_pending: got %0d left required 0", sb.size());
            sb.delete();
        end
        $display("test_power_loss done");
    endtask

    task automatic test_config_latch();
        RESET_B = 1'b0;
        repeat (2) @(negedge CLK);
        test_power_up(1'b1, 1'b1);
        base = edge_cnt;
        for (int e = 1; e <= 6; e++)
            expect_at(e, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3), "cfg_hold");
        VCCHIB_MODE = 1'b0;
        USE_FILT    = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            while (sb.size() != 0 && sb[0].at_edge <= edge_cnt) begin
                it = sb.pop_front();
                n_cmp++;
                if (outs() !== it.val) begin
                    n_err++;
                    $display("FAIL %s edge+%0d: got %b required %b", it.name, it.at_edge - base, outs(), it.val);
                end
            end
            VCCHIB_MODE = ~VCCHIB_MODE;
            USE_FILT    = ~USE_FILT;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL config_pending: got %0d left required 0", sb.size());
            sb.delete();
        end
        VCCHIB_MODE = 1'b0;
        USE_FILT    = 1'b0;
        $display("test_config_latch done");
    endtask

    task automatic test_async_reset();
        #2;
        RESET_B = 1'b0;
        #1;
        n_cmp++;
        if (outs() !== V_OFF) begin
            n_err++;
            $display("FAIL async_reset: got %b required %b", outs(), V_OFF);
        end
        @(negedge CLK);
        test_power_up(1'b0, 1'b0);
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_power_up(1'b0, 1'b0);
        test_glitch();
        test_real_reset();
        test_sw_reset();
        test_power_loss();
        test_config_latch();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
